// File: rtl/seq_chunk_adder_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_chunk_adder_subtractor_pkg
// Brief    : FSM state encoding and sizing helpers for the chunked adder.
// Revision : 1.0 - initial release
// ============================================================================
package seq_chunk_adder_subtractor_pkg;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_CALC = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = C_ST_IDLE,
        ST_CALC = C_ST_CALC,
        ST_DONE = C_ST_DONE
    } state_t;

    // A single-chunk configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int chunks);
        return (chunks <= 1) ? 1 : $clog2(chunks);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_chunk_adder_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_chunk_adder_subtractor_if
// Brief    : Operand/result handshake bundle for the chunked adder.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_chunk_adder_subtractor_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         add_n;
    logic         sat;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, x, y, add_n, sat, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, x, y, add_n, sat, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

endinterface
`default_nettype wire

// File: rtl/seq_chunk_adder_subtractor_rca.sv
`default_nettype none
// ============================================================================
// Module   : rca_nbit
// Brief    : Plain n-bit ripple-carry adder used as the per-cycle chunk slice.
// Revision : 1.0 - initial release
// ============================================================================
module rca_nbit #(
    parameter int n = 4
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         cin,
    output logic [n-1:0] s,
    output logic         cout
);

    logic [n:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar i = 0; i < n; i++) begin : g_bit
            assign s[i]     = x[i] ^ y[i] ^ w_c[i];
            assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
        end
    endgenerate

    assign cout = w_c[n];

endmodule
`default_nettype wire

// File: rtl/seq_chunk_adder_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : seq_chunk_adder_subtractor
// Brief    : Multi-cycle N-bit add/subtract, K bits per clock, with flags and
//            optional signed saturation behind valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module seq_chunk_adder_subtractor
    import seq_chunk_adder_subtractor_pkg::*;
#(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    seq_chunk_adder_subtractor_if.slave   bus
);

    localparam int              C_CHUNKS = N / K;
    localparam int              C_CW     = cnt_width(C_CHUNKS);
    localparam logic [C_CW-1:0] C_LAST   = C_CW'(C_CHUNKS - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [C_CW-1:0] r_cnt;
    logic            r_carry;
    logic            r_sat;
    logic [N-1:0]    r_x;
    logic [N-1:0]    r_yx;
    logic [N-1:0]    r_raw;
    logic [N-1:0]    r_sum;
    logic            r_cout;
    logic            r_ovf;
    logic            r_zero;

    logic            w_accept;
    logic            w_last;
    int unsigned     w_base;
    logic [K-1:0]    w_x_chunk;
    logic [K-1:0]    w_y_chunk;
    logic [K-1:0]    w_s_chunk;
    logic            w_cout_chunk;
    logic [N-1:0]    w_raw;
    logic            w_ovf;
    logic [N-1:0]    w_sat_val;
    logic [N-1:0]    w_sum_final;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == C_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Chunk slice: one K-bit ripple adder reused every CALC cycle
    // ------------------------------------------------------------------
    assign w_base    = 32'(r_cnt) * K;
    assign w_x_chunk = r_x[w_base +: K];
    assign w_y_chunk = r_yx[w_base +: K];

    rca_nbit #(
        .n    (K)
    ) u_rca (
        .x    (w_x_chunk),
        .y    (w_y_chunk),
        .cin  (r_carry),
        .s    (w_s_chunk),
        .cout (w_cout_chunk)
    );

    // Full raw result including the chunk being produced this cycle, so the
    // flags on the last chunk see every bit without an extra cycle.
    always_comb begin
        w_raw                = r_raw;
        w_raw[w_base +: K]   = w_s_chunk;
    end

    assign w_ovf       = (r_x[N-1] == r_yx[N-1]) && (w_raw[N-1] != r_x[N-1]);
    assign w_sat_val   = r_x[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    assign w_sum_final = (r_sat && w_ovf) ? w_sat_val : w_raw;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sat   <= 1'b0;
            r_x     <= '0;
            r_yx    <= '0;
            r_raw   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_x     <= bus.x;
            r_yx    <= bus.y ^ {N{bus.add_n}};
            r_sat   <= bus.sat;
            r_carry <= bus.add_n;
            r_cnt   <= '0;
        end else if (r_state == ST_CALC) begin
            r_raw   <= w_raw;
            r_carry <= w_cout_chunk;
            if (w_last) begin
                r_sum  <= w_sum_final;
                r_cout <= w_cout_chunk;
                r_ovf  <= w_ovf;
                r_zero <= (w_sum_final == '0);
            end else begin
                r_cnt  <= r_cnt + C_CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_chunk_adder_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_chunk_adder_subtractor
// Brief    : Directed-vector bench for the chunked adder at K=4, K=16, K=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_chunk_adder_subtractor;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        an;
        logic        s;
        logic [15:0] es;
        logic        ec;
        logic        eo;
        logic        ez;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        tb_in_valid;
    logic [15:0] tb_x;
    logic [15:0] tb_y;
    logic        tb_add_n;
    logic        tb_sat;
    logic        tb_out_ready;
    int          sel;

    logic        mo_in_ready;
    logic        mo_out_valid;
    logic [15:0] mo_sum;
    logic        mo_cout;
    logic        mo_ovf;
    logic        mo_zero;

    int n_tests;
    int n_fail;
    vec_t vecs[8];

    seq_chunk_adder_subtractor_if #(.N(16)) b4  ();
    seq_chunk_adder_subtractor_if #(.N(16)) b16 ();
    seq_chunk_adder_subtractor_if #(.N(16)) b1  ();

    assign b4.in_valid   = tb_in_valid && (sel == 4);
    assign b4.out_ready  = tb_out_ready && (sel == 4);
    assign b4.x          = tb_x;
    assign b4.y          = tb_y;
    assign b4.add_n      = tb_add_n;
    assign b4.sat        = tb_sat;
    assign b16.in_valid  = tb_in_valid && (sel == 16);
    assign b16.out_ready = tb_out_ready && (sel == 16);
    assign b16.x         = tb_x;
    assign b16.y         = tb_y;
    assign b16.add_n     = tb_add_n;
    assign b16.sat       = tb_sat;
    assign b1.in_valid   = tb_in_valid && (sel == 1);
    assign b1.out_ready  = tb_out_ready && (sel == 1);
    assign b1.x          = tb_x;
    assign b1.y          = tb_y;
    assign b1.add_n      = tb_add_n;
    assign b1.sat        = tb_sat;

    seq_chunk_adder_subtractor #(.N(16), .K(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(b4));
    seq_chunk_adder_subtractor #(.N(16), .K(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    seq_chunk_adder_subtractor #(.N(16), .K(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(b1));

    always_comb begin
        mo_in_ready  = b4.in_ready;
        mo_out_valid = b4.out_valid;
        mo_sum       = b4.sum;
        mo_cout      = b4.cout;
        mo_ovf       = b4.ovf;
        mo_zero      = b4.zero;
        if (sel == 16) begin
            mo_in_ready  = b16.in_ready;
            mo_out_valid = b16.out_valid;
            mo_sum       = b16.sum;
            mo_cout      = b16.cout;
            mo_ovf       = b16.ovf;
            mo_zero      = b16.zero;
        end else if (sel == 1) begin
            mo_in_ready  = b1.in_ready;
            mo_out_valid = b1.out_valid;
            mo_sum       = b1.sum;
            mo_cout      = b1.cout;
            mo_ovf       = b1.ovf;
            mo_zero      = b1.zero;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Whole-width reference: {sum, cout, ovf, zero}
    function automatic logic [18:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic an, input logic s);
        logic [16:0] full;
        logic [15:0] bb;
        logic [15:0] r;
        logic        o;
        bb   = an ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'd0, an};
        r    = full[15:0];
        o    = (a[15] == bb[15]) && (r[15] != a[15]);
        if (s && o) r = a[15] ? 16'h8000 : 16'h7FFF;
        return {r, full[16], o, (r == 16'h0000)};
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic an,
                         input logic s, input bit rel,
                         output logic [15:0] gs, output logic gc, output logic go,
                         output logic gz, output int lat);
        int n;
        n = 0;
        while (!mo_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        tb_x        = a;
        tb_y        = b;
        tb_add_n    = an;
        tb_sat      = s;
        tb_in_valid = 1'b1;
        @(negedge clk);
        tb_in_valid = 1'b0;
        tb_x        = ~a;
        tb_y        = ~b;
        tb_add_n    = ~an;
        lat = 0;
        while (!mo_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        gs = mo_sum;
        gc = mo_cout;
        go = mo_ovf;
        gz = mo_zero;
        if (rel) begin
            tb_out_ready = 1'b1;
            @(negedge clk);
            tb_out_ready = 1'b0;
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v, input int exp_lat);
        logic [15:0] gs;
        logic        gc, go, gz;
        int          lat;
        do_op(v.x, v.y, v.an, v.s, 1'b1, gs, gc, go, gz, lat);
        chk({tag, " sum"},  32'(gs),  32'(v.es));
        chk({tag, " cout"}, 32'(gc),  32'(v.ec));
        chk({tag, " ovf"},  32'(go),  32'(v.eo));
        chk({tag, " zero"}, 32'(gz),  32'(v.ez));
        chk({tag, " lat"},  32'(lat), 32'(exp_lat));
        chk({tag, " in_ready after"}, 32'(mo_in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] gs;
        logic        gc, go, gz;
        int          lat;
        logic [18:0] r;
        vec_t        v;

        n_tests = 0;
        n_fail  = 0;
        //           x         y         an    s     sum       c     o     z
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h0000, 16'h8000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};

        sel          = 4;
        rst_n        = 1'b0;
        tb_in_valid  = 1'b0;
        tb_x         = '0;
        tb_y         = '0;
        tb_add_n     = 1'b0;
        tb_sat       = 1'b0;
        tb_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("reset in_ready",  32'(mo_in_ready),  32'd1);
        chk("reset out_valid", 32'(mo_out_valid), 32'd0);
        chk("reset sum",       32'(mo_sum),       32'd0);
        chk("reset cout",      32'(mo_cout),      32'd0);
        chk("reset ovf",       32'(mo_ovf),       32'd0);
        chk("reset zero",      32'(mo_zero),      32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("k4 vec%0d", i), vecs[i], 4);
        end

        // Backpressure: hold result while a new request is offered
        do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, gs, gc, go, gz, lat);
        chk("bp sum", 32'(gs), 32'h3333);
        chk("bp lat", 32'(lat), 32'd4);
        tb_x        = 16'hFFFF;
        tb_y        = 16'hFFFF;
        tb_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d out_valid", i), 32'(mo_out_valid), 32'd1);
            chk($sformatf("bp hold%0d in_ready", i),  32'(mo_in_ready),  32'd0);
            chk($sformatf("bp hold%0d sum", i),       32'(mo_sum),       32'h3333);
        end
        tb_in_valid  = 1'b0;
        tb_out_ready = 1'b1;
        @(negedge clk);
        tb_out_ready = 1'b0;
        chk("bp release out_valid", 32'(mo_out_valid), 32'd0);
        chk("bp release in_ready",  32'(mo_in_ready),  32'd1);
        chk("bp release sum",       32'(mo_sum),       32'h3333);
        @(negedge clk);
        chk("bp idle in_ready", 32'(mo_in_ready), 32'd1);

        // Asynchronous reset two chunks into an operation
        tb_x        = 16'h7FFF;
        tb_y        = 16'h0001;
        tb_add_n    = 1'b0;
        tb_sat      = 1'b0;
        tb_in_valid = 1'b1;
        @(negedge clk);
        tb_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort in_ready",  32'(mo_in_ready),  32'd1);
        chk("abort out_valid", 32'(mo_out_valid), 32'd0);
        chk("abort sum",       32'(mo_sum),       32'd0);
        chk("abort cout",      32'(mo_cout),      32'd0);
        chk("abort ovf",       32'(mo_ovf),       32'd0);
        chk("abort zero",      32'(mo_zero),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort no output", 32'(mo_out_valid), 32'd0);
        run_vec("post-abort", vecs[0], 4);

        // Single-chunk and bit-serial configurations
        for (int p = 0; p < 2; p++) begin
            sel = (p == 0) ? 16 : 1;
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                run_vec($sformatf("k%0d vec%0d", sel, i), vecs[i], 16 / sel);
            end
            for (int i = 0; i < 6; i++) begin
                v.x  = 16'($urandom);
                v.y  = 16'($urandom);
                v.an = 1'($urandom);
                v.s  = 1'($urandom);
                r    = ref_model(v.x, v.y, v.an, v.s);
                v.es = r[18:3];
                v.ec = r[2];
                v.eo = r[1];
                v.ez = r[0];
                run_vec($sformatf("k%0d rnd%0d", sel, i), v, 16 / sel);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
